rob_param: RTL and testbench
============================

ROB_PARAM -- requirements
Module: rob_param

Interface
REQ-001 ROB_SIZE, default 16, number of entries; any value 2..64, need not be a power of two.
REQ-002 IDX_W, default $clog2(ROB_SIZE), width of entry indices.
REQ-003 NUM_CPL, default 3, number of independent completion ports (ALU, cache, mul).
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_alloc_valid  input  1  decode requests allocation.
REQ-007 in_alloc_pc / in_alloc_rd / in_alloc_type  input  32/5/3  PC, destination register, instr type of the new entry.
REQ-008 out_alloc_ready  output  1  allocation accepted this cycle (!out_full && !in_stall && !out_flush).
REQ-009 out_alloc_idx  output  IDX_W  index the new entry receives (= tail).
REQ-010 in_cpl_valid  input  NUM_CPL  per-port completion strobe.
REQ-011 in_cpl_idx / in_cpl_value / in_cpl_exc  input  NUM_CPL*IDX_W / NUM_CPL*32 / NUM_CPL*3  packed per-port index, result, exception code.
REQ-012 in_stall  input  1  freezes allocation and commit; completion still accepted.
REQ-013 out_commit_valid  output  1  head entry retires this cycle.
REQ-014 out_commit_pc / out_commit_value / out_commit_rd / out_commit_type / out_commit_exc / out_commit_idx  output  32/32/5/3/3/IDX_W  retiring entry fields.
REQ-015 out_flush  output  1  head has a nonzero exception and is retiring; pipeline nuke.
REQ-016 out_full / out_empty  output  1 each  count == ROB_SIZE / count == 0.
REQ-017 out_count  output  IDX_W+1  occupied entries.
REQ-018 in_rs1 / in_rs2  input  5 each  execute-stage source registers (bypass).
REQ-019 out_rs1_hit / out_rs1_value / out_rs2_hit / out_rs2_value  output  1/32/1/32  bypass result.

Function
REQ-020 The block SHALL keep registered head, tail and count; pointers SHALL wrap from ROB_SIZE-1 to 0.
REQ-021 On accepted allocation, the entry at tail SHALL be written valid=1, complete=0, exc=0, rd forced to 0 when type is STORE; tail advances next edge.
REQ-022 A completion SHALL set value, exc and complete=1 on the next edge; completions to invalid entries SHALL be ignored.
REQ-023 Same-index completions on several ports in one cycle: highest-numbered port wins.
REQ-024 Commit SHALL be combinational: out_commit_valid=1 when head is valid, complete and !in_stall; entry clears and head advances on that edge; minimum complete-to-commit latency is one cycle.
REQ-025 count SHALL +1 on allocate, -1 on commit, unchanged when both occur in the same cycle; allocation at full SHALL be refused.
REQ-026 If the committing head has exc != 0, out_flush=1 and out_commit_valid=1 that cycle; next edge all entries invalid, head=tail=count=0; that cycle's allocation and completions are dropped.
REQ-027 Bypass SHALL return the youngest valid, complete entry whose rd matches, searching tail-1 back to head with wrap; rd==0 never hits; value 0 on miss.
REQ-028 All commit outputs SHALL be 0 when out_commit_valid=0.

Reset
REQ-029 On reset: head=tail=count=0, every entry invalid, out_full=0, out_empty=1, all other outputs 0; reset overrides flush, allocation and completion in the same cycle.

Configuration
REQ-030 ROB_BYPASS_EN defined: REQ-027 bypass search compiled in; undefined: search logic omitted, out_rs1_hit/out_rs2_hit and values tied to 0.

Verification
REQ-031 Allocate 16 entries (ROB_SIZE=16) -> out_full=1, 17th request gives out_alloc_ready=0, out_count=16.
REQ-032 Allocate idx0..2, complete 2,1,0 in order -> commits 0,1,2 on consecutive cycles, out_empty=1 after.
REQ-033 Ports 0 and 2 complete idx 5 same cycle with 0x11/0x22 -> committed value 0x22.
REQ-034 Head completes with exc=3'b001 -> out_flush=1 one cycle, next cycle out_count=0, out_alloc_idx=0.
REQ-035 ROB_SIZE=10, fill/drain 25 entries -> out_alloc_idx wraps 9->0, commits in program order.
REQ-036 With ROB_BYPASS_EN: idx3 and idx6 both rd=7 complete (0xA/0xB), in_rs1=7 -> out_rs1_hit=1, value 0xB; in_rs2=0 -> no hit.

Source files
------------

// File: rtl/rob_param.sv
// rob_param -- parameterised reorder buffer.
//
// Allocates entries in program order at the tail, accepts out-of-order
// completions on NUM_CPL independent ports and retires the head entry
// combinationally once it is complete. A completing head with a nonzero
// exception code raises out_flush and empties the buffer on the next edge.
//
// Parameters:
//   ROB_SIZE  number of entries (2..64, any value)
//   IDX_W     entry index width
//   NUM_CPL   number of completion ports (highest-numbered port wins a tie)
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   in_alloc_*  / out_alloc_*      allocation request, ready and assigned index
//   in_cpl_*                       packed per-port completion strobe/index/value/exc
//   in_stall                       freezes allocation and commit
//   out_commit_*, out_flush        retiring entry fields, exception flush
//   out_full, out_empty, out_count occupancy
//   in_rs1/2, out_rs1/2_*          source-register bypass lookup
//
// Configuration macro:
//   ROB_BYPASS_EN  defined: bypass search compiled in;
//                  undefined: bypass outputs tied to 0.

module rob_param #(
  parameter int unsigned ROB_SIZE = 16,
  parameter int unsigned IDX_W    = $clog2(ROB_SIZE),
  parameter int unsigned NUM_CPL  = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_alloc_valid,
  input  logic [31:0]              in_alloc_pc,
  input  logic [4:0]               in_alloc_rd,
  input  logic [2:0]               in_alloc_type,
  output logic                     out_alloc_ready,
  output logic [IDX_W-1:0]         out_alloc_idx,
  input  logic [NUM_CPL-1:0]       in_cpl_valid,
  input  logic [NUM_CPL*IDX_W-1:0] in_cpl_idx,
  input  logic [NUM_CPL*32-1:0]    in_cpl_value,
  input  logic [NUM_CPL*3-1:0]     in_cpl_exc,
  input  logic                     in_stall,
  output logic                     out_commit_valid,
  output logic [31:0]              out_commit_pc,
  output logic [31:0]              out_commit_value,
  output logic [4:0]               out_commit_rd,
  output logic [2:0]               out_commit_type,
  output logic [2:0]               out_commit_exc,
  output logic [IDX_W-1:0]         out_commit_idx,
  output logic                     out_flush,
  output logic                     out_full,
  output logic                     out_empty,
  output logic [IDX_W:0]           out_count,
  input  logic [4:0]               in_rs1,
  input  logic [4:0]               in_rs2,
  output logic                     out_rs1_hit,
  output logic [31:0]              out_rs1_value,
  output logic                     out_rs2_hit,
  output logic [31:0]              out_rs2_value
);

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(ROB_SIZE - 1);
  localparam logic [IDX_W:0]   FULL_CNT   = (IDX_W + 1)'(ROB_SIZE);
  // Stores write no register, so their rd is forced to 0 and never bypasses.
  localparam logic [2:0]       TYPE_STORE = 3'd2;

  // Pointer increment with wrap at ROB_SIZE-1 (size need not be a power of two).
  function automatic logic [IDX_W-1:0] f_next(input logic [IDX_W-1:0] p);
    return (p == LAST_IDX) ? '0 : p + 1'b1;
  endfunction

  logic [IDX_W-1:0]    r_head;
  logic [IDX_W-1:0]    r_tail;
  logic [IDX_W:0]      r_count;
  logic [ROB_SIZE-1:0] r_valid;
  logic [ROB_SIZE-1:0] r_complete;
  logic [31:0]         r_pc    [ROB_SIZE];
  logic [31:0]         r_value [ROB_SIZE];
  logic [4:0]          r_rd    [ROB_SIZE];
  logic [2:0]          r_type  [ROB_SIZE];
  logic [2:0]          r_exc   [ROB_SIZE];

  logic w_alloc;
  logic w_commit;

  assign out_full  = (r_count == FULL_CNT);
  assign out_empty = (r_count == '0);
  assign out_count = r_count;

  // Reset gating keeps every handshake output low while reset is held.
  assign w_commit        = !reset && r_valid[r_head] && r_complete[r_head] && !in_stall;
  assign out_flush       = w_commit && (r_exc[r_head] != 3'd0);
  assign out_alloc_ready = !reset && !out_full && !in_stall && !out_flush;
  assign out_alloc_idx   = r_tail;
  assign w_alloc         = out_alloc_ready && in_alloc_valid;

  always_ff @(posedge clk) begin
    if (reset || out_flush) begin
      // Flush discards this cycle's allocation and completions as well.
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_complete <= '0;
    end else begin
      // Ports scanned in ascending order so the last (highest) port wins.
      for (int i = 0; i < ROB_SIZE; i++) begin
        for (int p = 0; p < NUM_CPL; p++) begin
          if (r_valid[i] && in_cpl_valid[p] &&
              (in_cpl_idx[p*IDX_W +: IDX_W] == IDX_W'(i))) begin
            r_complete[i] <= 1'b1;
            r_value[i]    <= in_cpl_value[p*32 +: 32];
            r_exc[i]      <= in_cpl_exc[p*3 +: 3];
          end
        end
      end

      if (w_commit) begin
        r_valid[r_head]    <= 1'b0;
        r_complete[r_head] <= 1'b0;
        r_head             <= f_next(r_head);
      end

      // Tail entry is invalid whenever allocation is accepted, so no
      // completion above can target it in the same cycle.
      if (w_alloc) begin
        r_valid[r_tail]    <= 1'b1;
        r_complete[r_tail] <= 1'b0;
        r_exc[r_tail]      <= 3'd0;
        r_value[r_tail]    <= 32'd0;
        r_pc[r_tail]       <= in_alloc_pc;
        r_rd[r_tail]       <= (in_alloc_type == TYPE_STORE) ? 5'd0 : in_alloc_rd;
        r_type[r_tail]     <= in_alloc_type;
        r_tail             <= f_next(r_tail);
      end

      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    out_commit_valid = w_commit;
    out_commit_pc    = '0;
    out_commit_value = '0;
    out_commit_rd    = '0;
    out_commit_type  = '0;
    out_commit_exc   = '0;
    out_commit_idx   = '0;
    if (w_commit) begin
      out_commit_pc    = r_pc[r_head];
      out_commit_value = r_value[r_head];
      out_commit_rd    = r_rd[r_head];
      out_commit_type  = r_type[r_head];
      out_commit_exc   = r_exc[r_head];
      out_commit_idx   = r_head;
    end
  end

`ifdef ROB_BYPASS_EN
  // Index of the entry 'off' slots younger than head, modulo ROB_SIZE.
  function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base,
                                                 input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= ROB_SIZE) s = s - ROB_SIZE;
    return s[IDX_W-1:0];
  endfunction

  // Walk oldest to youngest inside the occupied window; later matches
  // overwrite earlier ones, leaving the youngest complete producer.
  always_comb begin
    logic [IDX_W-1:0] w_pos;
    out_rs1_hit   = 1'b0;
    out_rs1_value = '0;
    out_rs2_hit   = 1'b0;
    out_rs2_value = '0;
    w_pos         = '0;
    for (int unsigned k = 0; k < ROB_SIZE; k++) begin
      w_pos = f_wrap_add(r_head, k);
      if ((k < 32'(r_count)) && r_valid[w_pos] && r_complete[w_pos]) begin
        if ((in_rs1 != 5'd0) && (r_rd[w_pos] == in_rs1)) begin
          out_rs1_hit   = 1'b1;
          out_rs1_value = r_value[w_pos];
        end
        if ((in_rs2 != 5'd0) && (r_rd[w_pos] == in_rs2)) begin
          out_rs2_hit   = 1'b1;
          out_rs2_value = r_value[w_pos];
        end
      end
    end
  end
`else
  logic w_unused_rs;
  assign w_unused_rs   = ^{in_rs1, in_rs2};
  assign out_rs1_hit   = 1'b0;
  assign out_rs1_value = '0;
  assign out_rs2_hit   = 1'b0;
  assign out_rs2_value = '0;
`endif

endmodule

// File: tb/tb_rob_param.sv
// Self-checking bench for rob_param: a ROB_SIZE=16 instance (a_*) for the
// table vectors and corner sequences, and a ROB_SIZE=10 instance (b_*) for
// the non-power-of-two wrap test. Both share the same input stimulus.

module tb_rob_param;

  logic        clk;
  logic        reset;
  logic        in_alloc_valid;
  logic [31:0] in_alloc_pc;
  logic [4:0]  in_alloc_rd;
  logic [2:0]  in_alloc_type;
  logic [2:0]  in_cpl_valid;
  logic [11:0] in_cpl_idx;
  logic [95:0] in_cpl_value;
  logic [8:0]  in_cpl_exc;
  logic        in_stall;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;

  logic        a_alloc_ready, a_commit_valid, a_flush, a_full, a_empty;
  logic [3:0]  a_alloc_idx, a_commit_idx;
  logic [31:0] a_commit_pc, a_commit_value, a_rs1_value, a_rs2_value;
  logic [4:0]  a_commit_rd, a_count;
  logic [2:0]  a_commit_type, a_commit_exc;
  logic        a_rs1_hit, a_rs2_hit;

  logic        b_alloc_ready, b_commit_valid, b_flush, b_full, b_empty;
  logic [3:0]  b_alloc_idx, b_commit_idx;
  logic [31:0] b_commit_pc, b_commit_value, b_rs1_value, b_rs2_value;
  logic [4:0]  b_commit_rd, b_count;
  logic [2:0]  b_commit_type, b_commit_exc;
  logic        b_rs1_hit, b_rs2_hit;

  rob_param #(.ROB_SIZE(16), .NUM_CPL(3)) u_dut_a (
    .clk(clk), .reset(reset),
    .in_alloc_valid(in_alloc_valid), .in_alloc_pc(in_alloc_pc),
    .in_alloc_rd(in_alloc_rd), .in_alloc_type(in_alloc_type),
    .out_alloc_ready(a_alloc_ready), .out_alloc_idx(a_alloc_idx),
    .in_cpl_valid(in_cpl_valid), .in_cpl_idx(in_cpl_idx),
    .in_cpl_value(in_cpl_value), .in_cpl_exc(in_cpl_exc), .in_stall(in_stall),
    .out_commit_valid(a_commit_valid), .out_commit_pc(a_commit_pc),
    .out_commit_value(a_commit_value), .out_commit_rd(a_commit_rd),
    .out_commit_type(a_commit_type), .out_commit_exc(a_commit_exc),
    .out_commit_idx(a_commit_idx), .out_flush(a_flush), .out_full(a_full),
    .out_empty(a_empty), .out_count(a_count), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_rs1_hit(a_rs1_hit), .out_rs1_value(a_rs1_value),
    .out_rs2_hit(a_rs2_hit), .out_rs2_value(a_rs2_value)
  );

  rob_param #(.ROB_SIZE(10), .NUM_CPL(3)) u_dut_b (
    .clk(clk), .reset(reset),
    .in_alloc_valid(in_alloc_valid), .in_alloc_pc(in_alloc_pc),
    .in_alloc_rd(in_alloc_rd), .in_alloc_type(in_alloc_type),
    .out_alloc_ready(b_alloc_ready), .out_alloc_idx(b_alloc_idx),
    .in_cpl_valid(in_cpl_valid), .in_cpl_idx(in_cpl_idx),
    .in_cpl_value(in_cpl_value), .in_cpl_exc(in_cpl_exc), .in_stall(in_stall),
    .out_commit_valid(b_commit_valid), .out_commit_pc(b_commit_pc),
    .out_commit_value(b_commit_value), .out_commit_rd(b_commit_rd),
    .out_commit_type(b_commit_type), .out_commit_exc(b_commit_exc),
    .out_commit_idx(b_commit_idx), .out_flush(b_flush), .out_full(b_full),
    .out_empty(b_empty), .out_count(b_count), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_rs1_hit(b_rs1_hit), .out_rs1_value(b_rs1_value),
    .out_rs2_hit(b_rs2_hit), .out_rs2_value(b_rs2_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    in_alloc_valid = 1'b0;
    in_alloc_pc    = 32'd0;
    in_alloc_rd    = 5'd0;
    in_alloc_type  = 3'd0;
    in_cpl_valid   = 3'd0;
    in_cpl_idx     = 12'd0;
    in_cpl_value   = 96'd0;
    in_cpl_exc     = 9'd0;
    in_stall       = 1'b0;
    in_rs1         = 5'd0;
    in_rs2         = 5'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc(input logic [31:0] pc, input logic [4:0] rd, input logic [2:0] typ);
    in_alloc_valid = 1'b1;
    in_alloc_pc    = pc;
    in_alloc_rd    = rd;
    in_alloc_type  = typ;
  endtask

  task automatic set_cpl(input int port, input logic [3:0] idx, input logic [31:0] val,
                         input logic [2:0] exc);
    in_cpl_valid[port]         = 1'b1;
    in_cpl_idx[port*4 +: 4]    = idx;
    in_cpl_value[port*32 +: 32] = val;
    in_cpl_exc[port*3 +: 3]    = exc;
  endtask

  // Allocation is requested while reset is held to show reset wins.
  task automatic do_reset(input logic check);
    idle();
    reset = 1'b1;
    alloc(32'hDEAD, 5'd9, 3'd0);
    tick();
    tick();
    if (check) begin
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_full", 32'(a_full), 32'd0);
      chk("rst_ready", 32'(a_alloc_ready), 32'd0);
      chk("rst_idx", 32'(a_alloc_idx), 32'd0);
      chk("rst_cvalid", 32'(a_commit_valid), 32'd0);
      chk("rst_flush", 32'(a_flush), 32'd0);
      chk("rst_cpc", a_commit_pc, 32'd0);
    end
    idle();
    reset = 1'b0;
  endtask

  typedef struct {
    logic        alloc_v;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [2:0]  typ;
    logic        cpl_v;
    int          port;
    logic [3:0]  cidx;
    logic [31:0] cval;
    logic        stall;
    logic        e_ready;
    logic [3:0]  e_idx;
    logic        e_cv;
    logic [31:0] e_pc;
    logic [31:0] e_val;
    logic [4:0]  e_rd;
    logic [4:0]  e_count;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl [NVEC];

  int n_alloc, n_cpl, n_com, exp_next;
  logic issue_a, issue_c, exp_cv;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // alloc_v pc rd typ | cpl_v port idx val | stall | ready idx cv pc val rd count
    tbl[0]  = '{1'b1, 32'h100, 5'd1, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd0, 1'b0, 32'h000, 32'h00, 5'd0, 5'd0};
    tbl[1]  = '{1'b1, 32'h104, 5'd2, 3'd2, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd1, 1'b0, 32'h000, 32'h00, 5'd0, 5'd1};
    tbl[2]  = '{1'b1, 32'h108, 5'd3, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd2, 1'b0, 32'h000, 32'h00, 5'd0, 5'd2};
    tbl[3]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b1, 0, 4'd2, 32'h33, 1'b0,
                1'b1, 4'd3, 1'b0, 32'h000, 32'h00, 5'd0, 5'd3};
    tbl[4]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b1, 1, 4'd1, 32'h22, 1'b0,
                1'b1, 4'd3, 1'b0, 32'h000, 32'h00, 5'd0, 5'd3};
    tbl[5]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b1, 2, 4'd0, 32'h11, 1'b0,
                1'b1, 4'd3, 1'b0, 32'h000, 32'h00, 5'd0, 5'd3};
    tbl[6]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd3, 1'b1, 32'h100, 32'h11, 5'd1, 5'd3};
    tbl[7]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd3, 1'b1, 32'h104, 32'h22, 5'd0, 5'd2};
    tbl[8]  = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd3, 1'b1, 32'h108, 32'h33, 5'd3, 5'd1};
    tbl[9]  = '{1'b1, 32'h10C, 5'd4, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b1,
                1'b0, 4'd3, 1'b0, 32'h000, 32'h00, 5'd0, 5'd0};
    tbl[10] = '{1'b1, 32'h10C, 5'd4, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd3, 1'b0, 32'h000, 32'h00, 5'd0, 5'd0};
    tbl[11] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b1, 0, 4'd3, 32'h44, 1'b1,
                1'b0, 4'd4, 1'b0, 32'h000, 32'h00, 5'd0, 5'd1};
    tbl[12] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b1,
                1'b0, 4'd4, 1'b0, 32'h000, 32'h00, 5'd0, 5'd1};
    tbl[13] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd4, 1'b1, 32'h10C, 32'h44, 5'd4, 5'd1};
    tbl[14] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b1, 2, 4'd4, 32'h55, 1'b0,
                1'b1, 4'd4, 1'b0, 32'h000, 32'h00, 5'd0, 5'd0};
    tbl[15] = '{1'b1, 32'h110, 5'd5, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd4, 1'b0, 32'h000, 32'h00, 5'd0, 5'd0};
    tbl[16] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd5, 1'b0, 32'h000, 32'h00, 5'd0, 5'd1};
    tbl[17] = '{1'b0, 32'h000, 5'd0, 3'd0, 1'b0, 0, 4'd0, 32'h00, 1'b0,
                1'b1, 4'd5, 1'b0, 32'h000, 32'h00, 5'd0, 5'd1};

    idle();
    reset = 1'b1;
    do_reset(1'b1);

    // Table: in-order commit after reverse completion, stall, invalid completion.
    for (int i = 0; i < NVEC; i++) begin
      idle();
      if (tbl[i].alloc_v) alloc(tbl[i].pc, tbl[i].rd, tbl[i].typ);
      if (tbl[i].cpl_v) set_cpl(tbl[i].port, tbl[i].cidx, tbl[i].cval, 3'd0);
      in_stall = tbl[i].stall;
      #1;
      chk($sformatf("v%0d_ready", i), 32'(a_alloc_ready), 32'(tbl[i].e_ready));
      chk($sformatf("v%0d_idx", i), 32'(a_alloc_idx), 32'(tbl[i].e_idx));
      chk($sformatf("v%0d_cvalid", i), 32'(a_commit_valid), 32'(tbl[i].e_cv));
      chk($sformatf("v%0d_cpc", i), a_commit_pc, tbl[i].e_pc);
      chk($sformatf("v%0d_cval", i), a_commit_value, tbl[i].e_val);
      chk($sformatf("v%0d_crd", i), 32'(a_commit_rd), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d_count", i), 32'(a_count), 32'(tbl[i].e_count));
      tick();
    end
    idle();

    // Fill to 16, 17th request refused.
    do_reset(1'b0);
    for (int i = 0; i < 16; i++) begin
      idle();
      alloc(32'h400 + 32'(i), 5'd1, 3'd0);
      #1;
      chk($sformatf("fill%0d_ready", i), 32'(a_alloc_ready), 32'd1);
      chk($sformatf("fill%0d_idx", i), 32'(a_alloc_idx), 32'(i));
      tick();
    end
    idle();
    alloc(32'h500, 5'd1, 3'd0);
    #1;
    chk("full_flag", 32'(a_full), 32'd1);
    chk("full_ready", 32'(a_alloc_ready), 32'd0);
    chk("full_count", 32'(a_count), 32'd16);
    tick();
    idle();
    #1;
    chk("full_count_after", 32'(a_count), 32'd16);
    chk("full_tail_wrap", 32'(a_alloc_idx), 32'd0);

    // Ports 0 and 2 complete idx5 together; port 2 must win.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) begin
      idle();
      alloc(32'h600 + 32'(4 * i), 5'd2, 3'd0);
      tick();
    end
    exp_next = 0;
    for (int c = 0; c < 30 && exp_next < 6; c++) begin
      idle();
      if (c < 5) set_cpl(1, 4'(c), 32'hA0 + 32'(c), 3'd0);
      if (c == 0) begin
        set_cpl(0, 4'd5, 32'h11, 3'd0);
        set_cpl(2, 4'd5, 32'h22, 3'd0);
      end
      #1;
      if (a_commit_valid) begin
        chk($sformatf("tie_order%0d", exp_next), 32'(a_commit_idx), 32'(exp_next));
        if (exp_next == 5) chk("tie_value", a_commit_value, 32'h22);
        exp_next++;
      end
      tick();
    end
    chk("tie_commits", 32'(exp_next), 32'd6);
    idle();
    #1;
    chk("tie_empty", 32'(a_empty), 32'd1);

    // Exception at head: one-cycle flush, then empty.
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      alloc(32'h700 + 32'(4 * i), 5'd3, 3'd0);
      tick();
    end
    idle();
    set_cpl(0, 4'd0, 32'h77, 3'b001);
    set_cpl(1, 4'd1, 32'h55, 3'd0);
    #1;
    chk("exc_pre_cvalid", 32'(a_commit_valid), 32'd0);
    tick();
    idle();
    alloc(32'h800, 5'd4, 3'd0);
    set_cpl(2, 4'd2, 32'h66, 3'd0);
    #1;
    chk("exc_flush", 32'(a_flush), 32'd1);
    chk("exc_cvalid", 32'(a_commit_valid), 32'd1);
    chk("exc_code", 32'(a_commit_exc), 32'd1);
    chk("exc_cidx", 32'(a_commit_idx), 32'd0);
    chk("exc_ready", 32'(a_alloc_ready), 32'd0);
    tick();
    idle();
    #1;
    chk("exc_post_flush", 32'(a_flush), 32'd0);
    chk("exc_post_count", 32'(a_count), 32'd0);
    chk("exc_post_idx", 32'(a_alloc_idx), 32'd0);
    chk("exc_post_empty", 32'(a_empty), 32'd1);
    chk("exc_post_cvalid", 32'(a_commit_valid), 32'd0);

    // ROB_SIZE=10: stream 25 entries, indices wrap 9->0, program-order commit.
    do_reset(1'b0);
    n_alloc = 0;
    n_cpl   = 0;
    n_com   = 0;
    for (int c = 0; c < 300 && n_com < 25; c++) begin
      idle();
      issue_a = (n_alloc < 25) && (n_alloc - n_com < 10);
      issue_c = (n_cpl < n_alloc) && ((n_alloc - n_cpl >= 8) || (n_alloc == 25));
      if (issue_a) alloc(32'h1000 + 32'(4 * n_alloc), 5'(n_alloc % 31 + 1), 3'd0);
      if (issue_c) set_cpl(0, 4'(n_cpl % 10), 32'h5000 + 32'(n_cpl), 3'd0);
      exp_cv = (n_com < n_cpl);
      #1;
      chk($sformatf("wrap_c%0d_count", c), 32'(b_count), 32'(n_alloc - n_com));
      chk($sformatf("wrap_c%0d_ready", c), 32'(b_alloc_ready),
          32'(n_alloc - n_com != 10));
      chk($sformatf("wrap_c%0d_idx", c), 32'(b_alloc_idx), 32'(n_alloc % 10));
      chk($sformatf("wrap_c%0d_cvalid", c), 32'(b_commit_valid), 32'(exp_cv));
      if (exp_cv) begin
        chk($sformatf("wrap_c%0d_cpc", c), b_commit_pc, 32'h1000 + 32'(4 * n_com));
        chk($sformatf("wrap_c%0d_cval", c), b_commit_value, 32'h5000 + 32'(n_com));
        n_com++;
      end
      if (issue_a) n_alloc++;
      if (issue_c) n_cpl++;
      tick();
    end
    chk("wrap_commits", 32'(n_com), 32'd25);

    // Bypass: idx3 and idx6 both write rd=7.
    do_reset(1'b0);
    for (int i = 0; i < 7; i++) begin
      idle();
      alloc(32'h900 + 32'(4 * i), (i == 3 || i == 6) ? 5'd7 : 5'(10 + i), 3'd0);
      tick();
    end
    idle();
    set_cpl(0, 4'd3, 32'hA, 3'd0);
    tick();
    idle();
    in_rs1 = 5'd7;
    in_rs2 = 5'd12;
    set_cpl(1, 4'd6, 32'hB, 3'd0);
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_old_hit", 32'(a_rs1_hit), 32'd1);
    chk("byp_old_val", a_rs1_value, 32'hA);
    chk("byp_incomplete_hit", 32'(a_rs2_hit), 32'd0);
`else
    chk("byp_off_hit1", 32'(a_rs1_hit), 32'd0);
    chk("byp_off_val1", a_rs1_value, 32'd0);
`endif
    tick();
    idle();
    in_rs1 = 5'd7;
    in_rs2 = 5'd0;
    #1;
`ifdef ROB_BYPASS_EN
    chk("byp_young_hit", 32'(a_rs1_hit), 32'd1);
    chk("byp_young_val", a_rs1_value, 32'hB);
    chk("byp_rd0_hit", 32'(a_rs2_hit), 32'd0);
    chk("byp_rd0_val", a_rs2_value, 32'd0);
`else
    chk("byp_off_hit2", 32'(a_rs1_hit), 32'd0);
    chk("byp_off_val2", a_rs1_value, 32'd0);
    chk("byp_off_rs2", 32'(a_rs2_hit), 32'd0);
`endif
    chk("byp_no_commit", 32'(a_commit_valid), 32'd0);
    tick();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
